// File: rtl/types_pkg.sv
// Shared constants for the elastic pipeline: default payload width and the
// legal range for the number of register stages.
package types_pkg;

  localparam int XLEN      = 32;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 8;

  // Width of an occupancy counter that must reach 2*depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_if.sv
// Handshake bundle between an upstream producer, the elastic pipe and a
// downstream consumer, plus the per-stage flush and occupancy observation.
interface elastic_pipe_if
  import types_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int DEPTH = 2
) ();

  localparam int CW = count_width(DEPTH);

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; valid and data hold until that edge, ready may change freely.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [DEPTH-1:0] kill;
  logic [CW-1:0]    count;

  modport slave (
    input  in_valid, in_data, out_ready, kill,
    output in_ready, out_valid, out_data, count
  );

  modport master (
    output in_valid, in_data, out_ready, kill,
    input  in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/skid_stage.sv
// One elastic stage: a main register and a skid register, each with its own
// valid bit. Upstream ready comes straight from a flop, never from dn_ready.
module skid_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             kill,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data,
  output logic [1:0]       occ
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             enq;
  logic             deq;

  assign up_ready = ~skid_valid_q;
  assign enq      = up_valid & up_ready;
  assign deq      = main_valid_q & dn_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q && deq) begin
      main_data_d  = skid_data_q;
      skid_valid_d = 1'b0;
    end else if (enq && main_valid_q && !deq) begin
      skid_data_d  = up_data;
      skid_valid_d = 1'b1;
    end else if (enq) begin
      main_data_d  = up_data;
      main_valid_d = 1'b1;
    end else if (deq) begin
      main_valid_d = 1'b0;
    end
    // A flush drops whatever this stage holds or is receiving this cycle.
    if (kill) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Payload registers carry no reset; only the valid bits matter.
  always_ff @(posedge clk) begin
    main_data_q <= main_data_d;
    skid_data_q <= skid_data_d;
  end

  assign dn_valid = main_valid_q;
  assign dn_data  = main_data_q;
  assign occ      = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: rtl/elastic_pipe.sv
// Chain of DEPTH skid stages giving a fully registered valid/ready pipeline
// with 2*DEPTH entries of buffering and a per-stage flush.
module elastic_pipe
  import types_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  elastic_pipe_if.slave bus
);

  localparam int CW = count_width(DEPTH);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_check
    $error("elastic_pipe: DEPTH=%0d outside %0d..%0d", DEPTH, DEPTH_MIN, DEPTH_MAX);
  end

  // Link k is the upstream side of stage k; link DEPTH is the pipe output.
  logic [DEPTH:0]   link_valid;
  logic [DEPTH:0]   link_ready;
  logic [WIDTH-1:0] link_data [DEPTH+1];
  logic [1:0]       occ [DEPTH];
  logic [CW-1:0]    count_sum;

  assign link_valid[0]     = bus.in_valid;
  assign link_data[0]      = bus.in_data;
  assign link_ready[DEPTH] = bus.out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    skid_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .kill     (bus.kill[k]),
      .up_valid (link_valid[k]),
      .up_ready (link_ready[k]),
      .up_data  (link_data[k]),
      .dn_valid (link_valid[k+1]),
      .dn_ready (link_ready[k+1]),
      .dn_data  (link_data[k+1]),
      .occ      (occ[k])
    );
  end

  always_comb begin
    count_sum = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count_sum = count_sum + CW'(occ[k]);
    end
  end

  assign bus.in_ready  = link_ready[0];
  assign bus.out_valid = link_valid[DEPTH];
  assign bus.out_data  = link_data[DEPTH];
  assign bus.count     = count_sum;

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed and scoreboard bench for elastic_pipe at DEPTH=3, WIDTH=32.
module tb_elastic_pipe;

  localparam int W = 32;
  localparam int D = 3;

  typedef struct {
    logic         iv;
    logic [W-1:0] din;
    logic         ordy;
    logic [D-1:0] kill;
    logic         exp_ir;
    logic         exp_ov;
    logic [W-1:0] exp_od;
    logic [2:0]   exp_cnt;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  vec_t vecs [29];
  logic [W-1:0] exp_q [$];

  elastic_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();

  elastic_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic iv, input logic [W-1:0] din, input logic ordy,
                       input logic [D-1:0] k, input logic rst);
    bus.in_valid  = iv;
    bus.in_data   = din;
    bus.out_ready = ordy;
    bus.kill      = k;
    reset         = rst;
  endtask

  task automatic end_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    end_cycle();
    end_cycle();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [W-1:0] din, input logic ordy,
                              input logic [D-1:0] k, input logic ir, input logic ov,
                              input logic [W-1:0] od, input logic [2:0] cnt);
    vec_t v;
    v.iv = iv; v.din = din; v.ordy = ordy; v.kill = k;
    v.exp_ir = ir; v.exp_ov = ov; v.exp_od = od; v.exp_cnt = cnt;
    return v;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;

    // Fill to capacity with out_ready low, drain in order, then refill and
    // flush stage 1 while full.
    vecs[0]  = mk(1, 32'hA0, 0, 3'b000, 1, 0, 32'h0,  0);
    vecs[1]  = mk(1, 32'hA1, 0, 3'b000, 1, 0, 32'h0,  1);
    vecs[2]  = mk(1, 32'hA2, 0, 3'b000, 1, 0, 32'h0,  2);
    vecs[3]  = mk(1, 32'hA3, 0, 3'b000, 1, 1, 32'hA0, 3);
    vecs[4]  = mk(1, 32'hA4, 0, 3'b000, 1, 1, 32'hA0, 4);
    vecs[5]  = mk(1, 32'hA5, 0, 3'b000, 1, 1, 32'hA0, 5);
    vecs[6]  = mk(1, 32'hA6, 0, 3'b000, 0, 1, 32'hA0, 6);
    vecs[7]  = mk(1, 32'hA7, 0, 3'b000, 0, 1, 32'hA0, 6);
    vecs[8]  = mk(0, 32'h0,  0, 3'b000, 0, 1, 32'hA0, 6);
    vecs[9]  = mk(0, 32'h0,  1, 3'b000, 0, 1, 32'hA0, 6);
    vecs[10] = mk(0, 32'h0,  1, 3'b000, 0, 1, 32'hA1, 5);
    vecs[11] = mk(0, 32'h0,  1, 3'b000, 0, 1, 32'hA2, 4);
    vecs[12] = mk(0, 32'h0,  1, 3'b000, 1, 1, 32'hA3, 3);
    vecs[13] = mk(0, 32'h0,  1, 3'b000, 1, 1, 32'hA4, 2);
    vecs[14] = mk(0, 32'h0,  1, 3'b000, 1, 1, 32'hA5, 1);
    vecs[15] = mk(0, 32'h0,  1, 3'b000, 1, 0, 32'h0,  0);
    vecs[16] = mk(1, 32'hB0, 0, 3'b000, 1, 0, 32'h0,  0);
    vecs[17] = mk(1, 32'hB1, 0, 3'b000, 1, 0, 32'h0,  1);
    vecs[18] = mk(1, 32'hB2, 0, 3'b000, 1, 0, 32'h0,  2);
    vecs[19] = mk(1, 32'hB3, 0, 3'b000, 1, 1, 32'hB0, 3);
    vecs[20] = mk(1, 32'hB4, 0, 3'b000, 1, 1, 32'hB0, 4);
    vecs[21] = mk(1, 32'hB5, 0, 3'b000, 1, 1, 32'hB0, 5);
    vecs[22] = mk(0, 32'h0,  0, 3'b010, 0, 1, 32'hB0, 6);
    vecs[23] = mk(0, 32'h0,  0, 3'b000, 0, 1, 32'hB0, 4);
    vecs[24] = mk(0, 32'h0,  1, 3'b000, 1, 1, 32'hB0, 4);
    vecs[25] = mk(0, 32'h0,  1, 3'b000, 1, 1, 32'hB1, 3);
    vecs[26] = mk(0, 32'h0,  1, 3'b000, 1, 1, 32'hB4, 2);
    vecs[27] = mk(0, 32'h0,  1, 3'b000, 1, 1, 32'hB5, 1);
    vecs[28] = mk(0, 32'h0,  1, 3'b000, 1, 0, 32'h0,  0);

    // Reset state
    reset_dut();
    @(negedge clk);
    check("reset_out_valid", W'(bus.out_valid), W'(0));
    check("reset_in_ready",  W'(bus.in_ready),  W'(1));
    check("reset_count",     W'(bus.count),     W'(0));
    end_cycle();

    // Table-driven capacity / drain / kill sequence
    reset_dut();
    for (int i = 0; i < 29; i++) begin
      drive(vecs[i].iv, vecs[i].din, vecs[i].ordy, vecs[i].kill, 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i),  W'(bus.in_ready),  W'(vecs[i].exp_ir));
      check($sformatf("vec%0d_out_valid", i), W'(bus.out_valid), W'(vecs[i].exp_ov));
      check($sformatf("vec%0d_count", i),     W'(bus.count),     W'(vecs[i].exp_cnt));
      if (vecs[i].exp_ov)
        check($sformatf("vec%0d_out_data", i), bus.out_data, vecs[i].exp_od);
      end_cycle();
    end

    // Latency and full throughput: data 1,2,3,... from cycle 0
    reset_dut();
    for (int c = 0; c < 25; c++) begin
      drive(1'b1, W'(c + 1), 1'b1, '0, 1'b0);
      @(negedge clk);
      check($sformatf("tput%0d_in_ready", c), W'(bus.in_ready), W'(1));
      if (c < D) begin
        check($sformatf("tput%0d_out_valid", c), W'(bus.out_valid), W'(0));
      end else begin
        check($sformatf("tput%0d_out_valid", c), W'(bus.out_valid), W'(1));
        check($sformatf("tput%0d_out_data", c),  bus.out_data,      W'(c - D + 1));
        check($sformatf("tput%0d_count", c),     W'(bus.count),     W'(D));
      end
      end_cycle();
    end

    // Mid-stream reset with four entries held and in_valid high
    reset_dut();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, W'(32'h10 + c), 1'b0, '0, 1'b0);
      end_cycle();
    end
    drive(1'b1, 32'h99, 1'b0, '0, 1'b1);
    @(negedge clk);
    check("midrst_count_before", W'(bus.count), W'(4));
    end_cycle();
    drive(1'b1, 32'h55, 1'b1, '0, 1'b0);
    @(negedge clk);
    check("midrst_count",     W'(bus.count),     W'(0));
    check("midrst_out_valid", W'(bus.out_valid), W'(0));
    check("midrst_in_ready",  W'(bus.in_ready),  W'(1));
    end_cycle();
    for (int c = 1; c <= D; c++) begin
      drive(1'b0, '0, 1'b1, '0, 1'b0);
      @(negedge clk);
      if (c < D) begin
        check($sformatf("midrst_wait%0d_out_valid", c), W'(bus.out_valid), W'(0));
      end else begin
        check("midrst_first_out_valid", W'(bus.out_valid), W'(1));
        check("midrst_first_out_data",  bus.out_data,      32'h55);
      end
      end_cycle();
    end

    // Random traffic against a scoreboard
    reset_dut();
    exp_q.delete();
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), '0, 1'b0);
      @(negedge clk);
      check($sformatf("rand%0d_count", c), W'(bus.count), W'(exp_q.size()));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check($sformatf("rand%0d_spurious_out", c), W'(1), W'(0));
        end else begin
          check($sformatf("rand%0d_out_data", c), bus.out_data, exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(bus.in_data);
      end_cycle();
    end

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elastic_pipe.md
ELASTIC_PIPE -- requirements
Module: elastic_pipe

Interface
REQ-001: Parameter WIDTH, default XLEN (32); payload width in bits.
REQ-002: Parameter DEPTH, default 2; number of register stages, legal range 1..8.
REQ-003: The module SHALL have one clock and a synchronous, active-high reset: clk and reset, the same names the codebase uses.
REQ-004: clk  input  1  rising-edge clock for all state.
REQ-005: reset  input  1  synchronous, active-high; clears all valid state.
REQ-006: in_valid  input  1  upstream offers in_data.
REQ-007: in_ready  output  1  pipe accepts in_data this cycle.
REQ-008: in_data  input  WIDTH  upstream payload.
REQ-009: out_valid  output  1  out_data is valid.
REQ-010: out_ready  input  1  downstream consumes out_data this cycle; low means stall.
REQ-011: out_data  output  WIDTH  payload of the oldest entry.
REQ-012: kill  input  DEPTH  per-stage flush; bit k clears stage k (bit 0 is the input stage).
REQ-013: count  output  $clog2(2*DEPTH+1)  number of valid entries held in the pipe.

Function
REQ-014: Each stage SHALL hold a main entry and a skid entry, each with its own valid bit.
- Stage k upstream ready = NOT skid_valid[k]; this ready is a registered signal with no combinational path from out_ready.
- Stage k downstream valid/data = main valid/data.
REQ-015: Per stage per cycle: enq = up_valid & up_ready; deq = main_valid & dn_ready.
REQ-016: Stage update priority:
- (a) skid valid & deq: main<=skid, skid_valid<=0.
- (b) enq & main_valid & !deq: skid<=in, skid_valid<=1.
- (c) enq: main<=in, main_valid<=1.
- (d) deq only: main_valid<=0.
- (e) otherwise hold.
REQ-017: in_ready = stage-0 upstream ready; out_valid/out_data = stage DEPTH-1 main; stage k dn_ready = stage k+1 up_ready.
REQ-018: Latency: into an empty pipe with out_ready=1, data accepted at edge t SHALL be visible on out_valid/out_data after edge t+DEPTH-1, i.e. DEPTH cycles.
REQ-019: Throughput SHALL be one transfer per cycle in steady state with out_ready held high, with no bubbles.
REQ-020: Capacity SHALL be 2*DEPTH entries; in_ready SHALL deassert the cycle after the 2*DEPTH-th accept with no dequeues.
REQ-021: Simultaneous enq and deq on a full stage SHALL NOT occur, since ready is low while skid is valid; enq and deq on a stage with only main valid SHALL replace main with zero net change.
REQ-022: kill[k] SHALL clear main_valid[k] and skid_valid[k] at the next edge, overriding REQ-016.
- An enq into stage k in the same cycle is completed upstream but its data is discarded.
- A deq out of stage k in the same cycle still delivers to stage k+1.
REQ-023: kill of all ones SHALL empty the pipe in one cycle; count=0 the following cycle.
REQ-024: Payload registers SHALL NOT be cleared by kill or reset; only valid bits are.
REQ-025: count SHALL equal the registered sum of all valid bits and update the same cycle as the valid bits.

Reset
REQ-026: While reset is high at an edge, all valid bits SHALL be 0 after that edge, irrespective of enq, deq or kill.
REQ-027: Outputs after reset: out_valid=0, in_ready=1, count=0; out_data is don't-care.
REQ-028: Reset asserted mid-stream SHALL drop all held entries; the first accept after reset deassertion SHALL occur in the first cycle reset is low.

Structure
REQ-029: XLEN and the DEPTH legal-range constants SHALL live in types_pkg; no new typedefs are required.
REQ-030: One stage SHALL be a sub-module skid_stage (parameter WIDTH, ports clk, reset, kill, up/dn valid-ready-data, occ[1:0]); elastic_pipe SHALL instantiate DEPTH copies of it in a generate loop and sum occ into count.
REQ-031: An elaboration-time check SHALL reject DEPTH outside 1..8.

Verification
REQ-032: DEPTH=3, out_ready=1, in_valid=1 with data 1,2,3,... from cycle 0 -> out_valid rises at cycle 3 with out_data=1, then one increment per cycle with no gaps.
REQ-033: DEPTH=3, out_ready=0, push 0xA0..0xA7 -> exactly 6 accepted, in_ready=0 from cycle 6, count=6; raising out_ready then drains 0xA0..0xA5 in order.
REQ-034: Random in_valid/out_ready (50%) for 10k cycles -> scoreboard shows in-order, lossless, duplicate-free delivery, and count always equals outstanding entries.
REQ-035: Pipe full (count=6), pulse kill=3'b010 for one cycle -> count drops by 2 next cycle; surviving data stays in order, and stage-1 entries never appear on out_data.
REQ-036: reset asserted for 1 cycle with count=4 and in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1; the value pushed on the first post-reset cycle appears at out_data 3 cycles later.
